// File: rtl/io_peripheral_unit.sv
// io_peripheral_unit: memory-mapped I/O slave behind the memory controller's I/O window.
// Holds a UART transmitter fed by a TX FIFO, an interval timer, an LED register and a switch port.
// Optional feature macro: IO_TIMER_EN adds the interval timer (regs 2-4, STATUS[3], irq).
// Without IO_TIMER_EN, regs 2-4 read 0 and ignore writes, and irq is tied low.
module io_peripheral_unit #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  addressIO,
   input  logic [31:0] dataInIO,
   input  logic        wEnIO,
   input  logic        rstIO,
   output logic [31:0] dataOutIO,
   output logic        uart_tx,
   output logic [7:0]  leds,
   input  logic [7:0]  switches,
   output logic        irq
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uartState_t;

   // Register-file write decode
   logic writeTx, writeStatus, writeLeds;
   assign writeTx     = wEnIO && (addressIO == 4'd0);
   assign writeStatus = wEnIO && (addressIO == 4'd1);
   assign writeLeds   = wEnIO && (addressIO == 4'd5);

   // TX FIFO
   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [CNT_W-1:0] fifoCount;
   logic             fifoFull, fifoEmpty, fifoPush, fifoPop, txOverflow;

   assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
   assign fifoEmpty = (fifoCount == '0);
   // A push into a full FIFO is still accepted when the UART pops the head that same cycle
   assign fifoPush  = writeTx && (!fifoFull || fifoPop);

   // UART state
   uartState_t        state, stateNext;
   logic [BAUD_W-1:0] baudCnt, baudNext;
   logic [2:0]        bitIdx, bitNext;
   logic [7:0]        shiftReg, shiftNext;
   logic              txNext, baudDone, txBusy;

   assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign txBusy   = (state != UART_IDLE);

   // Timer view for the read mux / status
   logic [31:0] loadRd, ctrlRd, countRd;
   logic        flagRd;

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (fifoPush) fifoMem[wrPtr] <= dataInIO[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifoCount  <= '0;
         txOverflow <= 1'b0;
      end else begin
         if (fifoPush) wrPtr <= wrPtr + PTR_W'(1);
         if (fifoPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({fifoPush, fifoPop})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
         if (writeStatus)               txOverflow <= 1'b0;
         else if (writeTx && !fifoPush) txOverflow <= 1'b1;
      end
   end

   // UART state register; the line level is registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= UART_IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitIdx   <= bitNext;
         shiftReg <= shiftNext;
         uart_tx  <= txNext;
      end
   end

   // UART next-state: IDLE -> START -> DATA x8 (LSB first) -> STOP, STOP chains to START when data waits
   always_comb begin
      stateNext = state;
      baudNext  = baudCnt;
      bitNext   = bitIdx;
      shiftNext = shiftReg;
      txNext    = uart_tx;
      fifoPop   = 1'b0;
      case (state)
         UART_IDLE: begin
            txNext = 1'b1;
            if (!fifoEmpty) begin
               fifoPop   = 1'b1;
               shiftNext = fifoMem[rdPtr];
               baudNext  = '0;
               stateNext = UART_START;
               txNext    = 1'b0;
            end
         end
         UART_START: begin
            if (baudDone) begin
               baudNext  = '0;
               bitNext   = '0;
               stateNext = UART_DATA;
               txNext    = shiftReg[0];
            end else begin
               baudNext = baudCnt + BAUD_W'(1);
            end
         end
         UART_DATA: begin
            if (baudDone) begin
               baudNext = '0;
               if (bitIdx == 3'd7) begin
                  stateNext = UART_STOP;
                  txNext    = 1'b1;
               end else begin
                  bitNext   = bitIdx + 3'd1;
                  shiftNext = {1'b0, shiftReg[7:1]};
                  txNext    = shiftReg[1];
               end
            end else begin
               baudNext = baudCnt + BAUD_W'(1);
            end
         end
         UART_STOP: begin
            if (baudDone) begin
               baudNext = '0;
               if (!fifoEmpty) begin
                  fifoPop   = 1'b1;
                  shiftNext = fifoMem[rdPtr];
                  stateNext = UART_START;
                  txNext    = 1'b0;
               end else begin
                  stateNext = UART_IDLE;
                  txNext    = 1'b1;
               end
            end else begin
               baudNext = baudCnt + BAUD_W'(1);
            end
         end
         default: stateNext = UART_IDLE;
      endcase
   end

`ifdef IO_TIMER_EN
   logic        writeLoad, writeCtrl;
   logic [31:0] timerLoad, timerCount;
   logic        timerEn, timerAuto, timerIe, timerFlag;
   logic        timerExpire, timerStart;

   assign writeLoad   = wEnIO && (addressIO == 4'd2);
   assign writeCtrl   = wEnIO && (addressIO == 4'd3);
   assign timerExpire = timerEn && (timerCount == '0);
   assign timerStart  = writeCtrl && dataInIO[0] && !timerEn;

   // Down-counter: load on EN rising, reload or stop on zero; expiry beats a same-cycle flag clear
   always_ff @(posedge clk) begin
      if (rst) begin
         timerLoad  <= '0;
         timerCount <= '0;
         timerEn    <= 1'b0;
         timerAuto  <= 1'b0;
         timerIe    <= 1'b0;
         timerFlag  <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (writeLoad) timerLoad <= dataInIO;
         if (timerStart) begin
            timerCount <= timerLoad;
         end else if (timerExpire) begin
            if (timerAuto) timerCount <= timerLoad;
         end else if (timerEn) begin
            timerCount <= timerCount - 32'd1;
         end
         if (writeCtrl) begin
            timerEn   <= dataInIO[0];
            timerAuto <= dataInIO[1];
            timerIe   <= dataInIO[2];
         end else if (timerExpire && !timerAuto) begin
            timerEn <= 1'b0;
         end
         if (timerExpire)                   timerFlag <= 1'b1;
         else if (writeCtrl && dataInIO[3]) timerFlag <= 1'b0;
         irq <= timerFlag & timerIe;
      end
   end

   assign loadRd  = timerLoad;
   assign ctrlRd  = {29'd0, timerIe, timerAuto, timerEn};
   assign countRd = timerCount;
   assign flagRd  = timerFlag;
`else
   logic unusedData;
   assign unusedData = ^dataInIO[31:8];
   assign loadRd     = '0;
   assign ctrlRd     = '0;
   assign countRd    = '0;
   assign flagRd     = 1'b0;
   assign irq        = 1'b0;
`endif

   // LED register and two-flop switch synchroniser
   logic [7:0] swMeta, swSync;
   always_ff @(posedge clk) begin
      if (rst) begin
         leds   <= '0;
         swMeta <= '0;
         swSync <= '0;
      end else begin
         if (writeLeds) leds <= dataInIO[7:0];
         swMeta <= switches;
         swSync <= swMeta;
      end
   end

   // Read mux
   logic [31:0] readMux;
   always_comb begin
      readMux = '0;
      case (addressIO)
         4'd1:    readMux = {20'd0, 4'(fifoCount), 3'd0, txOverflow, flagRd,
                             fifoEmpty, fifoFull, txBusy};
         4'd2:    readMux = loadRd;
         4'd3:    readMux = ctrlRd;
         4'd4:    readMux = countRd;
         4'd5:    readMux = {24'd0, leds};
         4'd6:    readMux = {24'd0, swSync};
         default: readMux = '0;
      endcase
   end

   // Registered read data, one-cycle latency; rstIO forces zero
   always_ff @(posedge clk) begin
      if (rst || rstIO) dataOutIO <= '0;
      else              dataOutIO <= readMux;
   end

endmodule
